// File: rtl/riscv_m_pkg.sv
// ---------------------------------------------------------------------------
// riscv_m_pkg
// Shared definitions for the RISC-V M-extension multiply/divide unit.
//   F3_*            funct3 encodings of the eight M-extension operations
//   muldiv_state_e  sequencer states of the iterative engine (3-bit encoding)
// ---------------------------------------------------------------------------
package riscv_m_pkg;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } muldiv_state_e;

endpackage

// File: rtl/riscv_muldiv_unit.sv
// ---------------------------------------------------------------------------
// riscv_muldiv_unit
// Iterative RV32M/RV64M multiply/divide engine. Multiplication is shift-add
// on operand magnitudes, division is restoring division on magnitudes; the
// sign is re-applied in a final fix-up cycle. One operation in flight at a
// time under a start/busy/done handshake.
//
// Ports
//   clk       in   system clock, all state on rising edge
//   reset     in   synchronous active-high reset
//   start_i   in   operation request, only honoured while idle
//   funct3_i  in   M-extension operation select (MUL..REMU)
//   a_i       in   rs1 operand, captured with start_i
//   b_i       in   rs2 operand, captured with start_i
//   busy_o    out  high from the cycle after an accepted start through done
//   done_o    out  one-cycle pulse, result_o valid in that cycle
//   result_o  out  result, held until the next accepted start
// ---------------------------------------------------------------------------
module riscv_muldiv_unit
    import riscv_m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam int IDX_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e state_q, state_d;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic              neg_res_q;
    logic              neg_rem_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   result_q;

    // Operand decode: which operands are signed, their magnitudes, and the
    // divide corner cases that bypass the iterative loop.
    logic            is_div;
    logic            div_signed;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_by_zero;
    logic            div_overflow;
    logic            special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        is_div       = op_q[2];
        div_signed   = (op_q == F3_DIV) || (op_q == F3_REM);
        a_signed     = (op_q == F3_MULH) || (op_q == F3_MULHSU) || div_signed;
        b_signed     = (op_q == F3_MULH) || div_signed;
        a_neg        = a_signed && a_q[XLEN-1];
        b_neg        = b_signed && b_q[XLEN-1];
        a_mag        = a_neg ? (~a_q + 1'b1) : a_q;
        b_mag        = b_neg ? (~b_q + 1'b1) : b_q;
        div_by_zero  = is_div && (b_q == '0);
        div_overflow = div_signed && (a_q == MIN_NEG) && (b_q == '1);
        special      = div_by_zero || div_overflow;
        special_res  = '0;
        // funct3 bit 1 distinguishes the remainder ops from the quotient ops
        if (div_by_zero) begin
            special_res = op_q[1] ? a_q : '1;
        end else if (div_overflow) begin
            special_res = op_q[1] ? '0 : a_q;
        end
    end

    // One iteration step. For multiply, bit idx of |b| gates |a|<<idx into
    // the accumulator. For divide, the upper half of the accumulator is the
    // partial remainder and the lower half collects quotient bits MSB-first.
    logic [IDX_W-1:0]  idx;
    logic [2*XLEN-1:0] partial;
    logic [XLEN:0]     rem_shift;
    logic [XLEN-1:0]   rem_sub;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   quo_next;

    always_comb begin
        idx       = cnt_q[IDX_W-1:0];
        partial   = b_q[idx] ? ({{XLEN{1'b0}}, a_q} << idx) : '0;
        rem_shift = {acc_q[2*XLEN-1:XLEN], a_q[idx]};
        rem_ge    = rem_shift >= {1'b0, b_q};
        // when rem_ge holds the difference is below the divisor, so the
        // XLEN-bit wrap-around subtraction is exact
        rem_sub   = rem_shift[XLEN-1:0] - b_q;
        rem_next  = rem_ge ? rem_sub : rem_shift[XLEN-1:0];
        quo_next  = acc_q[XLEN-1:0];
        quo_next[idx] = rem_ge;
    end

    // Sign fix-up and final result selection.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        fix_res  = '0;
        case (op_q)
            F3_MUL:                       fix_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_res = quo_fix;
            default:                      fix_res = rem_fix;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: corner-case divides skip straight from PREP to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_PREP;
            S_PREP:  state_d = special ? S_DONE : S_CALC;
            S_CALC:  if (cnt_q == '0) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers. Operands are replaced by their magnitudes in PREP,
    // so the raw inputs are never consulted after the start cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_q <= funct3_i;
                        a_q  <= a_i;
                        b_q  <= b_i;
                    end
                end
                S_PREP: begin
                    a_q       <= a_mag;
                    b_q       <= b_mag;
                    neg_res_q <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    acc_q     <= '0;
                    cnt_q     <= CNT_W'(XLEN - 1);
                    if (special) begin
                        result_q <= special_res;
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        acc_q <= {rem_next, quo_next};
                    end else begin
                        acc_q <= acc_q + partial;
                    end
                    cnt_q <= cnt_q - 1'b1;
                end
                S_FIX: begin
                    result_q <= fix_res;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_riscv_muldiv_unit
// Self-checking bench for riscv_muldiv_unit (XLEN=32). Directed cases carry
// hand-computed expectations; random cases are checked against a reference
// model built from plain 64-bit signed/unsigned arithmetic.
// ---------------------------------------------------------------------------
module tb_riscv_muldiv_unit;

    localparam int XLEN = 32;
    localparam int LAT_NORMAL  = XLEN + 3;
    localparam int LAT_SPECIAL = 2;

    logic            clk;
    logic            reset;
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    int n_compared;
    int n_mismatched;

    riscv_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result straight from the RISC-V M-extension definitions.
    function automatic logic [31:0] refResult(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (f)
            3'd0: p = ua * ub;
            3'd1: p = sa * sb;
            3'd2: p = sa * longint'(ub);
            3'd3: p = ua * ub;
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub;
            end
        endcase
        if (f == 3'd1 || f == 3'd2 || f == 3'd3) return p[63:32];
        return p[31:0];
    endfunction

    // Expected start-to-done latency: divide corner cases bypass the loop.
    function automatic int refLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f >= 3'd4 && b == 32'd0) return LAT_SPECIAL;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_SPECIAL;
        return LAT_NORMAL;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 20);
            4:       return 32'd0 - $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issues one operation in the current (idle) cycle, scrambles the live
    // inputs while busy, optionally pulses a stray start mid-calculation,
    // then checks latency, result and the handshake around done.
    task automatic applyStimulus(input string tag, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp_res,
                                 input int exp_lat, input bit inject);
        int n;
        bit seen;
        seen     = 1'b0;
        funct3_i = f;
        a_i      = a;
        b_i      = b;
        start_i  = 1'b1;
        for (n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                start_i = 1'b0;
                checkOutput({tag, " busy_after_start"}, 64'(busy_o), 64'd1);
            end
            funct3_i = 3'($urandom_range(0, 7));
            a_i      = $urandom;
            b_i      = $urandom;
            if (inject && n == 10) start_i = 1'b1;
            if (inject && n == 11) start_i = 1'b0;
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        start_i = 1'b0;
        if (!seen) begin
            checkOutput({tag, " done_timeout"}, 64'd0, 64'd1);
        end else begin
            checkOutput({tag, " latency"}, 64'(n), 64'(exp_lat));
            checkOutput({tag, " result"}, 64'(result_o), 64'(exp_res));
            checkOutput({tag, " busy_at_done"}, 64'(busy_o), 64'd1);
        end
        @(posedge clk);
        #1;
        checkOutput({tag, " busy_after_done"}, 64'(busy_o), 64'd0);
        checkOutput({tag, " done_pulse"}, 64'(done_o), 64'd0);
        checkOutput({tag, " result_held"}, 64'(result_o), 64'(exp_res));
    endtask

    initial begin
        int dones;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        n_compared   = 0;
        n_mismatched = 0;
        reset    = 1'b1;
        start_i  = 1'b0;
        funct3_i = 3'd0;
        a_i      = '0;
        b_i      = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 64'(busy_o), 64'd0);
        checkOutput("reset done", 64'(done_o), 64'd0);
        checkOutput("reset result", 64'(result_o), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // directed cases with hand-computed expectations
        applyStimulus("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 1'b0);
        applyStimulus("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 1'b0);
        applyStimulus("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35, 1'b0);
        applyStimulus("mulhsu_-1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 1'b0);
        applyStimulus("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 1'b0);
        applyStimulus("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 1'b0);
        applyStimulus("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 35, 1'b0);
        applyStimulus("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 35, 1'b0);
        applyStimulus("div_x_0", 3'd4, 32'd1234, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
        applyStimulus("rem_5_0", 3'd6, 32'd5, 32'd0, 32'd5, 2, 1'b0);
        applyStimulus("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0);
        applyStimulus("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 1'b0);
        applyStimulus("divu_x_0", 3'd5, 32'd77, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
        applyStimulus("remu_x_0", 3'd7, 32'd77, 32'd0, 32'd77, 2, 1'b0);
        applyStimulus("mul_stray_start", 3'd0, 32'd1000, 32'd3000, 32'd3000000, 35, 1'b1);
        applyStimulus("div_stray_start", 3'd4, 32'd99, 32'hFFFF_FFFD, 32'hFFFF_FFDF, 35, 1'b1);

        // reset in the middle of a calculation discards the operation
        funct3_i = 3'd0;
        a_i      = 32'd5;
        b_i      = 32'd6;
        start_i  = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset busy", 64'(busy_o), 64'd0);
        checkOutput("midreset result", 64'(result_o), 64'd0);
        checkOutput("midreset done", 64'(done_o), 64'd0);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_o) dones++;
        end
        checkOutput("midreset no_done", 64'(dones), 64'd0);
        applyStimulus("after_reset", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 35, 1'b0);

        // randomized operations checked against the reference model
        for (int i = 0; i < 150; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = pickOperand();
            rb = pickOperand();
            applyStimulus($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb,
                          refResult(rf, ra, rb), refLatency(rf, ra, rb),
                          ($urandom_range(0, 3) == 0) && (refLatency(rf, ra, rb) == LAT_NORMAL));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
